key_scan_ctrl: RTL and testbench
================================

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk_i cycles per scan tick (range 2..65535).
REQ-002 Parameter DEB_CNT, default 20, scan ticks a row pattern must stay stable to count as debounced (range 1..255).
REQ-003 Parameter REP_DLY, default 50, ticks between repeat events; used only under KEY_REPEAT_EN.
REQ-004 clk_i  in  1  system clock; the only clock.
REQ-005 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 row_i4  in  4  keypad rows, pulled up, low = pressed; asynchronous to clk_i.
REQ-007 col_o4  out  4  keypad column drive, active-low.
REQ-008 key_value_o8  out  8  last latched key code.
REQ-009 key_int_o  out  1  key event pending, level.
REQ-010 key_sta_o  out  1  debounced key-held status.
REQ-011 key_clr_i  in  1  MCU clear request, level from the register block; asynchronous to clk_i.

Function
REQ-012 row_i4 and key_clr_i SHALL each pass through a 2-flop synchronizer before use.
- All latencies below count from the synchronizer outputs.
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0.
- tick is asserted for one clk_i cycle at count CLK_DIV-1.
- The FSM advances only on tick.
REQ-014 FSM states: IDLE, DEB_PRESS, SCAN, LATCH, DEB_REL.
REQ-015 IDLE SHALL drive col_o4=4'b0000.
- Go to DEB_PRESS when synced rows != 4'hF on a tick.
REQ-016 DEB_PRESS SHALL count ticks while rows != 4'hF.
- Return to IDLE if rows == 4'hF on any tick.
- Go to SCAN after DEB_CNT consecutive ticks.
REQ-017 SCAN SHALL drive exactly one column low per tick, order col0..col3.
- The row sample for column k is taken on the tick after that column is driven, so each column settles for one tick.
REQ-018 First hit in scan order (lowest column, then lowest row) SHALL win; later hits are ignored.
REQ-019 If no column hits, the FSM SHALL return to IDLE with no event and no output change.
REQ-020 LATCH SHALL, for one tick:
- set key_value_o8={4'b0000,row_idx[1:0],col_idx[1:0]}, range 8'h00..8'h0F;
- set key_int_o=1;
- go to DEB_REL with col_o4=4'b0000.
REQ-021 key_sta_o SHALL be 1 from entry to LATCH until DEB_REL exits, else 0.
REQ-022 DEB_REL SHALL go to IDLE after DEB_CNT consecutive ticks with rows == 4'hF.
- Any pressed tick resets that count.
REQ-023 A rising edge of synced key_clr_i SHALL clear key_int_o on the next clk_i.
- Holding key_clr_i high SHALL NOT block later events.
REQ-024 If the LATCH set and a clear edge fall on the same clk_i, set SHALL win.
REQ-025 A new event while key_int_o=1 SHALL overwrite key_value_o8 and keep key_int_o=1.
REQ-026 Clear edge detection and the synchronizers SHALL run every clk_i, independent of tick.

Reset
REQ-027 While rst_n_i=0 the block SHALL hold, asynchronously:
- state IDLE, prescaler and counters 0;
- col_o4=4'b0000, key_value_o8=8'h00, key_int_o=0, key_sta_o=0;
- synchronizer and edge flops 0.
REQ-028 Reset mid-scan SHALL abort with no event.
- Operation resumes from IDLE on the first clk_i after release.

Configuration
REQ-029 With macro KEY_REPEAT_EN defined:
- DEB_REL SHALL count ticks while the key stays held;
- every REP_DLY ticks it SHALL re-assert key_int_o with an unchanged key_value_o8;
- release resets the repeat counter.
REQ-030 Without KEY_REPEAT_EN, one press SHALL produce exactly one event, and REP_DLY and the repeat counter SHALL be absent.

Verification (CLK_DIV=4, DEB_CNT=3, REP_DLY=5)
REQ-031 Reset release, rows=4'hF for 100 clk -> col_o4=0, key_int_o=0, key_sta_o=0, key_value_o8=8'h00.
REQ-032 Press row2/col1 (stable) -> key_value_o8=8'h09, key_int_o=1, key_sta_o=1.
- Release -> key_sta_o=0 after 3 clean ticks.
- key_int_o stays 1 until a key_clr_i rising edge, then 0.
REQ-033 Press glitch held 2 ticks, then released -> no event, FSM back in IDLE, key_int_o=0.
REQ-034 Press row0/col0 and row3/col3 together -> key_value_o8=8'h00.
- Clear edge on the LATCH clk -> key_int_o=1.
REQ-035 Assert rst_n_i low during SCAN, then release -> all outputs reset.
- The next press is detected normally.
REQ-036 KEY_REPEAT_EN defined, key row1/col3 held 20 ticks after latch, clearing after each event -> key_int_o re-asserts at 5, 10, 15, 20 ticks, key_value_o8=8'h07 each time.
- Macro undefined -> single event only.

Source files
------------

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: synchronizes rows, debounces press/release, scans columns and
// latches a key code with a pending-event flag. Define KEY_REPEAT_EN for auto-repeat events.
module key_scan_ctrl #(
   parameter int CLK_DIV = 1000,
   parameter int DEB_CNT = 20
`ifdef KEY_REPEAT_EN
   ,
   parameter int REP_DLY = 50
`endif
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] row_i4,
   output logic [3:0] col_o4,
   output logic [7:0] key_value_o8,
   output logic       key_int_o,
   output logic       key_sta_o,
   input  logic       key_clr_i
);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      SCAN,
      LATCH,
      DEB_REL
   } state_t;

   logic [3:0]  row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic        clr_s1_q, clr_s1_d, clr_s2_q, clr_s2_d, clr_prev_q, clr_prev_d;
   logic [15:0] presc_q, presc_d;
   state_t      state_q, state_d;
   logic [7:0]  deb_q, deb_d;
   logic [1:0]  scan_col_q, scan_col_d;
   logic        hit_q, hit_d;
   logic [1:0]  hit_row_q, hit_row_d;
   logic [1:0]  hit_col_q, hit_col_d;
   logic [3:0]  col_q, col_d;
   logic [7:0]  value_q, value_d;
   logic        int_q, int_d;
   logic        sta_q, sta_d;
`ifdef KEY_REPEAT_EN
   logic [15:0] rep_q, rep_d;
`endif

   logic        tick;
   logic        rows_idle;
   logic        clr_rise;
   logic [1:0]  low_row;
   logic [1:0]  scan_nxt;

   assign tick      = (presc_q == 16'(CLK_DIV - 1));
   assign rows_idle = (row_s2_q == 4'hF);
   assign clr_rise  = clr_s2_q & ~clr_prev_q;
   assign scan_nxt  = scan_col_q + 2'd1;

   // Lowest pressed row wins when several rows are low in the same column.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_s2_q[i]) low_row = 2'(i);
      end
   end

   always_comb begin
      row_s1_d   = row_i4;
      row_s2_d   = row_s1_q;
      clr_s1_d   = key_clr_i;
      clr_s2_d   = clr_s1_q;
      clr_prev_d = clr_s2_q;
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
   end

   always_comb begin
      state_d    = state_q;
      deb_d      = deb_q;
      scan_col_d = scan_col_q;
      hit_d      = hit_q;
      hit_row_d  = hit_row_q;
      hit_col_d  = hit_col_q;
      col_d      = col_q;
      value_d    = value_q;
      int_d      = int_q;
`ifdef KEY_REPEAT_EN
      rep_d      = rep_q;
`endif

      if (clr_rise) int_d = 1'b0;

      if (tick) begin
         case (state_q)
            IDLE: begin
               col_d = 4'b0000;
               if (!rows_idle) begin
                  state_d = DEB_PRESS;
                  deb_d   = 8'd0;
               end
            end
            DEB_PRESS: begin
               if (rows_idle) begin
                  state_d = IDLE;
                  deb_d   = 8'd0;
               end else if (deb_q == 8'(DEB_CNT - 1)) begin
                  state_d    = SCAN;
                  deb_d      = 8'd0;
                  scan_col_d = 2'd0;
                  hit_d      = 1'b0;
                  col_d      = 4'b1110;
               end else begin
                  deb_d = deb_q + 8'd1;
               end
            end
            SCAN: begin
               // Rows seen now belong to the column driven since the previous tick.
               if (!hit_q && !rows_idle) begin
                  hit_d     = 1'b1;
                  hit_row_d = low_row;
                  hit_col_d = scan_col_q;
               end
               if (scan_col_q == 2'd3) begin
                  col_d   = 4'b0000;
                  state_d = (hit_q || !rows_idle) ? LATCH : IDLE;
               end else begin
                  scan_col_d = scan_nxt;
                  col_d      = ~(4'b0001 << scan_nxt);
               end
            end
            LATCH: begin
               value_d = {4'b0000, hit_row_q, hit_col_q};
               int_d   = 1'b1;
               col_d   = 4'b0000;
               state_d = DEB_REL;
               deb_d   = 8'd0;
`ifdef KEY_REPEAT_EN
               rep_d   = 16'd0;
`endif
            end
            DEB_REL: begin
               if (rows_idle) begin
`ifdef KEY_REPEAT_EN
                  rep_d = 16'd0;
`endif
                  if (deb_q == 8'(DEB_CNT - 1)) begin
                     state_d = IDLE;
                     deb_d   = 8'd0;
                  end else begin
                     deb_d = deb_q + 8'd1;
                  end
               end else begin
                  deb_d = 8'd0;
`ifdef KEY_REPEAT_EN
                  if (rep_q == 16'(REP_DLY - 1)) begin
                     int_d = 1'b1;
                     rep_d = 16'd0;
                  end else begin
                     rep_d = rep_q + 16'd1;
                  end
`endif
               end
            end
            default: begin
               state_d = IDLE;
               col_d   = 4'b0000;
               deb_d   = 8'd0;
            end
         endcase
      end

      sta_d = (state_d == LATCH) || (state_d == DEB_REL);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         row_s1_q   <= 4'h0;
         row_s2_q   <= 4'h0;
         clr_s1_q   <= 1'b0;
         clr_s2_q   <= 1'b0;
         clr_prev_q <= 1'b0;
         presc_q    <= 16'd0;
         state_q    <= IDLE;
         deb_q      <= 8'd0;
         scan_col_q <= 2'd0;
         hit_q      <= 1'b0;
         hit_row_q  <= 2'd0;
         hit_col_q  <= 2'd0;
         col_q      <= 4'b0000;
         value_q    <= 8'h00;
         int_q      <= 1'b0;
         sta_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q      <= 16'd0;
`endif
      end else begin
         row_s1_q   <= row_s1_d;
         row_s2_q   <= row_s2_d;
         clr_s1_q   <= clr_s1_d;
         clr_s2_q   <= clr_s2_d;
         clr_prev_q <= clr_prev_d;
         presc_q    <= presc_d;
         state_q    <= state_d;
         deb_q      <= deb_d;
         scan_col_q <= scan_col_d;
         hit_q      <= hit_d;
         hit_row_q  <= hit_row_d;
         hit_col_q  <= hit_col_d;
         col_q      <= col_d;
         value_q    <= value_d;
         int_q      <= int_d;
         sta_q      <= sta_d;
`ifdef KEY_REPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

   assign col_o4       = col_q;
   assign key_value_o8 = value_q;
   assign key_int_o    = int_q;
   assign key_sta_o    = sta_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with a passive 4x4 keypad model (CLK_DIV=4, DEB_CNT=3).
module tb_key_scan_ctrl;

   localparam int CLK_DIV = 4;
   localparam int DEB_CNT = 3;
`ifdef KEY_REPEAT_EN
   localparam int REP_DLY = 5;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [7:0]  val;
   logic        intr;
   logic        sta;
   logic        clr = 1'b0;
   logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c held

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // A held key pulls its row low whenever its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (|(keys[r*4 +: 4] & ~col)) row[r] = 1'b0;
      end
   end

   key_scan_ctrl #(
      .CLK_DIV(CLK_DIV),
      .DEB_CNT(DEB_CNT)
`ifdef KEY_REPEAT_EN
      ,
      .REP_DLY(REP_DLY)
`endif
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .row_i4      (row),
      .col_o4      (col),
      .key_value_o8(val),
      .key_int_o   (intr),
      .key_sta_o   (sta),
      .key_clr_i   (clr)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic cur(input int which);
      case (which)
         0:       return intr;
         1:       return sta;
         default: return (col != 4'h0);
      endcase
   endfunction

   // Bounded wait on intr (0), sta (1) or an active column (2); an expired bound fails the check.
   task automatic wait_sig(input string tag, input int which, input logic lvl, input int budget);
      int n = 0;
      while (cur(which) !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {7'd0, cur(which)}, {7'd0, lvl});
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_col", {4'd0, col}, 8'h00);
      check("rst_int", {7'd0, intr}, 8'h00);
      check("rst_sta", {7'd0, sta}, 8'h00);
      check("rst_val", val, 8'h00);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_col", {4'd0, col}, 8'h00);
      check("idle_int", {7'd0, intr}, 8'h00);
      check("idle_sta", {7'd0, sta}, 8'h00);
      check("idle_val", val, 8'h00);

      // Row2/col1 press, release debounce, clear edge
      keys[9] = 1'b1;
      wait_sig("p21_int", 0, 1'b1, 300);
      check("p21_val", val, 8'h09);
      check("p21_sta", {7'd0, sta}, 8'h01);
      check("p21_col", {4'd0, col}, 8'h00);
      keys = 16'h0000;
      repeat (8) @(negedge clk);
      check("rel_sta_early", {7'd0, sta}, 8'h01);
      repeat (7) @(negedge clk);
      check("rel_sta_done", {7'd0, sta}, 8'h00);
      check("int_hold", {7'd0, intr}, 8'h01);
      clr = 1'b1;
      repeat (2) @(negedge clk);
      check("clr_sync_lat", {7'd0, intr}, 8'h01);
      repeat (2) @(negedge clk);
      check("clr_int", {7'd0, intr}, 8'h00);

      // Two-tick glitch with clear held high: no event
      repeat (8) @(negedge clk);
      keys[5] = 1'b1;
      repeat (8) @(negedge clk);
      keys = 16'h0000;
      repeat (60) @(negedge clk);
      check("gl_int", {7'd0, intr}, 8'h00);
      check("gl_sta", {7'd0, sta}, 8'h00);
      check("gl_col", {4'd0, col}, 8'h00);
      check("gl_val", val, 8'h09);

      // Clear still held high must not block a new event
      keys[2] = 1'b1;
      wait_sig("held_clr_int", 0, 1'b1, 300);
      check("held_clr_val", val, 8'h02);
      keys = 16'h0000;
      wait_sig("held_clr_rel", 1, 1'b0, 100);
      clr = 1'b0;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      repeat (4) @(negedge clk);
      check("clr2_int", {7'd0, intr}, 8'h00);
      clr = 1'b0;
      repeat (4) @(negedge clk);

      // Row0/col0 + row3/col3: first hit wins; clear edge on the LATCH clock loses to set
      keys[0]  = 1'b1;
      keys[15] = 1'b1;
      wait_sig("multi_sta", 1, 1'b1, 300);
      @(posedge clk);
      #1 clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("multi_pre_int", {7'd0, intr}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("multi_set_wins", {7'd0, intr}, 8'h01);
      check("multi_val", val, 8'h00);
      repeat (2) @(negedge clk);
      check("multi_int_keep", {7'd0, intr}, 8'h01);
      keys = 16'h0000;
      wait_sig("multi_rel", 1, 1'b0, 100);
      clr = 1'b0;

      // Reset during SCAN aborts; next press detected normally
      repeat (8) @(negedge clk);
      keys[6] = 1'b1;
      wait_sig("scan_seen", 2, 1'b1, 300);
      #1 rst_n = 1'b0;
      #1;
      check("rr_col", {4'd0, col}, 8'h00);
      check("rr_int", {7'd0, intr}, 8'h00);
      check("rr_sta", {7'd0, sta}, 8'h00);
      check("rr_val", val, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_sig("rr_int_after", 0, 1'b1, 300);
      check("rr_val_after", val, 8'h06);
      check("rr_sta_after", {7'd0, sta}, 8'h01);
      keys = 16'h0000;
      wait_sig("rr_rel", 1, 1'b0, 100);
      clr = 1'b1;
      repeat (4) @(negedge clk);
      check("rr_clr", {7'd0, intr}, 8'h00);
      clr = 1'b0;

      // Row1/col3 held long after latch
      repeat (8) @(negedge clk);
      keys[7] = 1'b1;
      wait_sig("hold_int", 0, 1'b1, 300);
      check("hold_val", val, 8'h07);
`ifdef KEY_REPEAT_EN
      for (int k = 0; k < 4; k++) begin
         clr = 1'b1;
         repeat (4) @(negedge clk);
         check("rep_clr", {7'd0, intr}, 8'h00);
         clr = 1'b0;
         repeat (14) @(negedge clk);
         check("rep_not_early", {7'd0, intr}, 8'h00);
         wait_sig("rep_int", 0, 1'b1, 4);
         check("rep_val", val, 8'h07);
      end
`else
      clr = 1'b1;
      repeat (4) @(negedge clk);
      check("single_clr", {7'd0, intr}, 8'h00);
      clr = 1'b0;
      repeat (100) @(negedge clk);
      check("single_no_repeat", {7'd0, intr}, 8'h00);
      check("single_sta", {7'd0, sta}, 8'h01);
`endif
      keys = 16'h0000;
      wait_sig("hold_rel", 1, 1'b0, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

endmodule
